hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5: register-address width.
REQ-002 SHALL have parameter MUL_LAT, default 4: multi-cycle HI/LO multiply latency in cycles, legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 16: performance-counter width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports rs1_D and rs2_D, input, RA_W each: source registers of the instruction in decode.
REQ-007 SHALL have ports rs1_E and rs2_E, input, RA_W each: source registers of the instruction in execute.
REQ-008 SHALL have ports wa_E, wa_M and wa_WB, input, RA_W each: destination registers per stage.
REQ-009 SHALL have ports we_reg_E, we_reg_M, we_reg_WB and dm2reg_E, input, 1 each: register-write and load flags.
REQ-010 SHALL have ports branch_taken_E, jump_D, mul_start_E and hilo_access_D, input, 1 each: control events.
REQ-011 SHALL have ports fwd_rd1_E and fwd_rd2_E, output, 2 each: forward select, 00 regfile, 01 M stage, 10 WB stage.
REQ-012 SHALL have ports stall_pc, stall_f2d, stall_d2e, stall_e2m and stall_m2wb, output, 1 each: stage hold signals.
REQ-013 SHALL have ports flush_f2d, flush_d2e and mul_busy, output, 1 each: bubble inserts and multiplier state.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, present only with HAZARD_PERF_EN.

Function
REQ-015 SHALL drive fwd_rdN_E = 01 when we_reg_M and wa_M == rsN_E and wa_M != 0; otherwise 10 when the same test holds for WB; otherwise 00. M has priority over WB.
REQ-016 SHALL flag load-use when dm2reg_E, we_reg_E, wa_E != 0 and wa_E equals rs1_D or rs2_D; it then asserts stall_pc, stall_f2d and flush_d2e in the same cycle (1-cycle bubble).
REQ-017 SHALL implement a multiplier FSM with states IDLE and BUSY; in IDLE, mul_start_E with MUL_LAT > 1 loads the down-counter with MUL_LAT-1 and enters BUSY.
REQ-018 SHALL, in BUSY, decrement the counter each cycle and return to IDLE on the edge where the counter reaches 0.
REQ-019 SHALL treat mul_start_E in BUSY as a restart: reload MUL_LAT-1 and remain in BUSY.
REQ-020 SHALL hold the FSM in IDLE when MUL_LAT == 1.
REQ-021 SHALL assert mul_busy exactly when the state is BUSY; mul_busy is a registered output.
REQ-022 SHALL, when hilo_access_D and mul_busy are both high, assert stall_pc, stall_f2d and flush_d2e.
REQ-023 SHALL, on branch_taken_E, assert flush_f2d and flush_d2e and deassert stall_pc and stall_f2d, overriding load-use and multiplier stalls.
REQ-024 SHALL, on jump_D without branch_taken_E, assert flush_f2d only; a simultaneous stall wins, so stall_f2d = 1 and flush_f2d = 0.
REQ-025 SHALL tie stall_d2e, stall_e2m and stall_m2wb to 0.
REQ-026 SHALL make every output except mul_busy and the counters a combinational function of the current inputs and state.

Reset
REQ-027 SHALL, on rst, immediately set the FSM to IDLE, the counter to 0, mul_busy to 0 and the performance counters to 0.
REQ-028 SHALL, on rst asserted mid-multiply, abandon the multiply; the first cycle after release has mul_busy = 0.

Configuration
REQ-029 SHALL, with HAZARD_PERF_EN defined, increment stall_cnt in every cycle stall_pc = 1 and flush_cnt in every cycle flush_d2e = 1, both saturating at 2^CNT_W-1.
REQ-030 SHALL, without HAZARD_PERF_EN, omit the counter ports and logic entirely; all other behaviour is identical.

Structure
REQ-031 SHALL place the FWD_RF/FWD_M/FWD_WB encodings and the mul_state_t enum (IDLE, BUSY) in package hazard_pkg.
REQ-032 SHALL implement the multiplier FSM and down-counter as sub-module mul_busy_ctr, parametrised by MUL_LAT.

Verification
REQ-033 SHALL cover: wa_M=3, we_reg_M=1, wa_WB=3, we_reg_WB=1, rs1_E=3 -> fwd_rd1_E=01; rs1_E=0 with wa_M=0 -> fwd_rd1_E=00.
REQ-034 SHALL cover: dm2reg_E=1, we_reg_E=1, wa_E=8, rs2_D=8 -> stall_pc=1, stall_f2d=1, flush_d2e=1 for exactly 1 cycle.
REQ-035 SHALL cover: MUL_LAT=4, mul_start_E pulse -> mul_busy high for 3 cycles; hilo_access_D held high -> stall_pc high in those 3 cycles, 0 after.
REQ-036 SHALL cover: load-use condition plus branch_taken_E=1 in the same cycle -> flush_f2d=1, flush_d2e=1, stall_pc=0.
REQ-037 SHALL cover: rst pulsed in the 2nd busy cycle -> mul_busy=0 immediately; the counters read 0 (with HAZARD_PERF_EN).
REQ-038 SHALL cover: CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects and multiplier FSM states.
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam int MUL_CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;
endpackage

// File: rtl/mul_busy_ctr.sv
// HI/LO multiplier occupancy tracker: busy for MUL_LAT-1 cycles after each start.
// A start while busy restarts the count.
module mul_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mul_start,
  output logic mul_busy
);
  localparam logic [MUL_CNT_W-1:0] RELOAD = MUL_CNT_W'(MUL_LAT - 1);

  mul_state_t           state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (mul_start && (MUL_LAT > 1)) begin
        state_d = BUSY;
        cnt_d   = RELOAD;
      end
      BUSY: if (mul_start) begin
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == MUL_CNT_W'(1)) state_d = IDLE;
      end
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign mul_busy = busy_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use / HI-LO stalls, branch/jump flushes.
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rs1_D,
  input  logic [RA_W-1:0] rs2_D,
  input  logic [RA_W-1:0] rs1_E,
  input  logic [RA_W-1:0] rs2_E,
  input  logic [RA_W-1:0] wa_E,
  input  logic [RA_W-1:0] wa_M,
  input  logic [RA_W-1:0] wa_WB,
  input  logic            we_reg_E,
  input  logic            we_reg_M,
  input  logic            we_reg_WB,
  input  logic            dm2reg_E,
  input  logic            branch_taken_E,
  input  logic            jump_D,
  input  logic            mul_start_E,
  input  logic            hilo_access_D,
  output logic [1:0]      fwd_rd1_E,
  output logic [1:0]      fwd_rd2_E,
  output logic            stall_pc,
  output logic            stall_f2d,
  output logic            stall_d2e,
  output logic            stall_e2m,
  output logic            stall_m2wb,
  output logic            flush_f2d,
  output logic            flush_d2e,
  output logic            mul_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
    $error("hazard_ctrl: MUL_LAT must be 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("hazard_ctrl: CNT_W must be >= 1");
  end

  logic m_hit1, m_hit2, wb_hit1, wb_hit2;
  logic load_use, hilo_stall, stall_req;

  assign m_hit1  = we_reg_M  && (wa_M  != '0) && (wa_M  == rs1_E);
  assign m_hit2  = we_reg_M  && (wa_M  != '0) && (wa_M  == rs2_E);
  assign wb_hit1 = we_reg_WB && (wa_WB != '0) && (wa_WB == rs1_E);
  assign wb_hit2 = we_reg_WB && (wa_WB != '0) && (wa_WB == rs2_E);

  assign fwd_rd1_E = m_hit1 ? FWD_M : (wb_hit1 ? FWD_WB : FWD_RF);
  assign fwd_rd2_E = m_hit2 ? FWD_M : (wb_hit2 ? FWD_WB : FWD_RF);

  mul_busy_ctr #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .mul_start(mul_start_E),
    .mul_busy (mul_busy)
  );

  assign load_use   = dm2reg_E && we_reg_E && (wa_E != '0) &&
                      ((wa_E == rs1_D) || (wa_E == rs2_D));
  assign hilo_stall = hilo_access_D && mul_busy;
  assign stall_req  = load_use || hilo_stall;

  // A taken branch squashes the younger instructions, so any stall on them is moot.
  always_comb begin
    stall_pc  = 1'b0;
    stall_f2d = 1'b0;
    flush_f2d = 1'b0;
    flush_d2e = 1'b0;
    if (branch_taken_E) begin
      flush_f2d = 1'b1;
      flush_d2e = 1'b1;
    end else begin
      stall_pc  = stall_req;
      stall_f2d = stall_req;
      flush_d2e = stall_req;
      flush_f2d = jump_D && !stall_req;
    end
  end

  assign stall_d2e  = 1'b0;
  assign stall_e2m  = 1'b0;
  assign stall_m2wb = 1'b0;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc  && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_d2e && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT=4, CNT_W=4); counter checks only with HAZARD_PERF_EN.
module tb_hazard_ctrl;
  localparam int RA_W = 5;
  localparam int MUL_LAT = 4;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [RA_W-1:0] rs1_D, rs2_D, rs1_E, rs2_E, wa_E, wa_M, wa_WB;
  logic            we_reg_E, we_reg_M, we_reg_WB, dm2reg_E;
  logic            branch_taken_E, jump_D, mul_start_E, hilo_access_D;
  logic [1:0]      fwd_rd1_E, fwd_rd2_E;
  logic            stall_pc, stall_f2d, stall_d2e, stall_e2m, stall_m2wb;
  logic            flush_f2d, flush_d2e, mul_busy;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .wa_E(wa_E), .wa_M(wa_M), .wa_WB(wa_WB),
    .we_reg_E(we_reg_E), .we_reg_M(we_reg_M), .we_reg_WB(we_reg_WB), .dm2reg_E(dm2reg_E),
    .branch_taken_E(branch_taken_E), .jump_D(jump_D),
    .mul_start_E(mul_start_E), .hilo_access_D(hilo_access_D),
    .fwd_rd1_E(fwd_rd1_E), .fwd_rd2_E(fwd_rd2_E),
    .stall_pc(stall_pc), .stall_f2d(stall_f2d), .stall_d2e(stall_d2e),
    .stall_e2m(stall_e2m), .stall_m2wb(stall_m2wb),
    .flush_f2d(flush_f2d), .flush_d2e(flush_d2e), .mul_busy(mul_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    {rs1_D, rs2_D, rs1_E, rs2_E, wa_E, wa_M, wa_WB} = '0;
    {we_reg_E, we_reg_M, we_reg_WB, dm2reg_E} = '0;
    {branch_taken_E, jump_D, mul_start_E, hilo_access_D} = '0;
  endtask

  task automatic set_load_use();
    dm2reg_E = 1'b1; we_reg_E = 1'b1; wa_E = 5'd8; rs2_D = 5'd8;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    #1;
    chk("rst_busy", 32'(mul_busy), 0);
    chk("rst_stall_pc", 32'(stall_pc), 0);
    chk("rst_fwd1", 32'(fwd_rd1_E), 0);
`ifdef HAZARD_PERF_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    tick(); tick();
    rst = 1'b0;

    // forwarding
    wa_M = 5'd3; we_reg_M = 1'b1; wa_WB = 5'd3; we_reg_WB = 1'b1; rs1_E = 5'd3; #1;
    chk("fwd_m_prio", 32'(fwd_rd1_E), 32'h1);
    we_reg_M = 1'b0; rs2_E = 5'd3; #1;
    chk("fwd_wb1", 32'(fwd_rd1_E), 32'h2);
    chk("fwd_wb2", 32'(fwd_rd2_E), 32'h2);
    clr_in(); we_reg_M = 1'b1; we_reg_WB = 1'b1; #1;
    chk("fwd_r0", 32'(fwd_rd1_E), 32'h0);
    wa_WB = 5'd5; rs2_E = 5'd5; wa_M = 5'd6; #1;
    chk("fwd_wb_only", 32'(fwd_rd2_E), 32'h2);
    chk("fwd_other_rf", 32'(fwd_rd1_E), 32'h0);
    chk("stall_consts", 32'({stall_d2e, stall_e2m, stall_m2wb}), 0);

    // load-use bubble for one cycle
    clr_in(); tick();
    set_load_use(); #1;
    chk("lu_stall_pc", 32'(stall_pc), 1);
    chk("lu_stall_f2d", 32'(stall_f2d), 1);
    chk("lu_flush_d2e", 32'(flush_d2e), 1);
    chk("lu_flush_f2d", 32'(flush_f2d), 0);
    tick(); clr_in(); #1;
    chk("lu_released", 32'({stall_pc, stall_f2d, flush_d2e}), 0);
    set_load_use(); wa_E = 5'd0; rs2_D = 5'd0; #1;
    chk("lu_r0_none", 32'(stall_pc), 0);

    // branch overrides, jump priority
    clr_in(); set_load_use(); branch_taken_E = 1'b1; #1;
    chk("br_flush", 32'({flush_f2d, flush_d2e}), 32'h3);
    chk("br_no_stall", 32'({stall_pc, stall_f2d}), 0);
    clr_in(); jump_D = 1'b1; #1;
    chk("jmp_flush", 32'({flush_f2d, flush_d2e, stall_f2d}), 32'h4);
    set_load_use(); #1;
    chk("jmp_stall_wins", 32'({flush_f2d, stall_f2d}), 32'h1);

    // multiplier busy window with HI/LO access held
    clr_in(); tick();
    mul_start_E = 1'b1; hilo_access_D = 1'b1; #1;
    chk("mul_pre_busy", 32'({mul_busy, stall_pc}), 0);
    tick(); mul_start_E = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mul_busy_c%0d", i), 32'({mul_busy, stall_pc, flush_d2e}), 32'h7);
      tick();
    end
    chk("mul_done", 32'({mul_busy, stall_pc}), 0);

    // restart while busy extends the window
    mul_start_E = 1'b1; tick();
    chk("mul_rs_a", 32'(mul_busy), 1);
    tick(); mul_start_E = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mul_rs_c%0d", i), 32'(mul_busy), 1);
      tick();
    end
    chk("mul_rs_done", 32'(mul_busy), 0);

    // reset in the 2nd busy cycle
    clr_in(); set_load_use(); tick(); tick(); clr_in();
    mul_start_E = 1'b1; tick(); mul_start_E = 1'b0;
    chk("mid_c1", 32'(mul_busy), 1);
    tick();
    chk("mid_c2", 32'(mul_busy), 1);
    rst = 1'b1; #1;
    chk("mid_rst_busy", 32'(mul_busy), 0);
`ifdef HAZARD_PERF_EN
    chk("mid_rst_scnt", 32'(stall_cnt), 0);
    chk("mid_rst_fcnt", 32'(flush_cnt), 0);
`endif
    tick(); rst = 1'b0; #1;
    chk("post_rst_busy", 32'(mul_busy), 0);
    tick();
    chk("post_rst_busy2", 32'(mul_busy), 0);

    // 20 consecutive stalls saturate a 4-bit counter
    set_load_use();
    for (int i = 0; i < 5; i++) tick();
`ifdef HAZARD_PERF_EN
    chk("cnt_5", 32'(stall_cnt), 5);
    chk("fcnt_5", 32'(flush_cnt), 5);
`endif
    for (int i = 0; i < 15; i++) tick();
    chk("sat_stall_pc", 32'(stall_pc), 1);
`ifdef HAZARD_PERF_EN
    chk("cnt_sat", 32'(stall_cnt), 15);
    chk("fcnt_sat", 32'(flush_cnt), 15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
